// File: rtl/cdb_arbiter_if.sv
// Result payload type and the execute-stage <-> CDB arbiter bus bundle.
package cdb_arbiter_pkg;
   localparam int unsigned ROB_IDX_W = 5;
   localparam int unsigned PREG_W    = 6;
   localparam int unsigned AREG_W    = 5;
   localparam int unsigned XLEN      = 32;

   typedef struct packed {
      logic                 valid;
      logic [ROB_IDX_W-1:0] rob_idx;
      logic [PREG_W-1:0]    pd_s;
      logic [AREG_W-1:0]    rd_s;
      logic [XLEN-1:0]      rd_v;
      logic [XLEN-1:0]      inst;
      logic                 pc_select;
      logic [XLEN-1:0]      pc_branch;
   } cdb_t;
endpackage

interface cdb_arbiter_if #(
   parameter int unsigned NUM_REQ = 5,
   parameter int unsigned NUM_CDB = 2
);
   import cdb_arbiter_pkg::*;

   logic                 global_branch_signal;
   cdb_t [NUM_REQ-1:0]   req_cdb;
   logic [NUM_REQ-1:0]   req_ready;
   cdb_t [NUM_CDB-1:0]   cdb_out;
   logic [NUM_REQ-1:0]   cdb_grant;
   logic                 overflow;

   modport master (
      output global_branch_signal, req_cdb,
      input  req_ready, cdb_out, cdb_grant, overflow
   );

   modport slave (
      input  global_branch_signal, req_cdb,
      output req_ready, cdb_out, cdb_grant, overflow
   );
endinterface

// File: rtl/cdb_arbiter.sv
// Per-requester result FIFOs sharing NUM_CDB broadcast ports with a rotating
// round-robin scan; flushed by global_branch_signal.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ   = 5,
   parameter int unsigned NUM_CDB   = 2,
   parameter int unsigned BUF_DEPTH = 2
) (
   input logic          clk,
   input logic          rst,
   cdb_arbiter_if.slave bus
);

   localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
   localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int unsigned RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned RK_W  = $clog2(NUM_REQ + 1);

   cdb_t               mem_q    [NUM_REQ][BUF_DEPTH];
   logic [PTR_W-1:0]   rd_ptr_q [NUM_REQ];
   logic [PTR_W-1:0]   rd_ptr_d [NUM_REQ];
   logic [PTR_W-1:0]   wr_ptr_q [NUM_REQ];
   logic [PTR_W-1:0]   wr_ptr_d [NUM_REQ];
   logic [CNT_W-1:0]   cnt_q    [NUM_REQ];
   logic [CNT_W-1:0]   cnt_d    [NUM_REQ];
   logic [RR_W-1:0]    rr_ptr_q;
   logic [RR_W-1:0]    rr_ptr_d;
   logic               overflow_q;
   logic               overflow_d;
   logic [NUM_REQ-1:0] ready_q;
   logic [NUM_REQ-1:0] ready_d;

   logic               kill;
   logic               flush;
   logic [NUM_REQ-1:0] nonempty;
   logic [NUM_REQ-1:0] full;
   logic [NUM_REQ-1:0] grant;
   logic [NUM_REQ-1:0] push;
   logic [RR_W-1:0]    pos  [NUM_REQ];
   logic [RK_W-1:0]    rank [NUM_REQ];
   cdb_t               head [NUM_REQ];
   cdb_t [NUM_CDB-1:0] slot;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign flush = bus.global_branch_signal;
   assign kill  = rst | flush;

   // FIFO status, head entries and each requester's distance from rr_ptr
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         nonempty[i] = (cnt_q[i] != '0);
         full[i]     = (cnt_q[i] == CNT_W'(BUF_DEPTH));
         head[i]     = mem_q[i][rd_ptr_q[i]];
         pos[i]      = RR_W'((i + NUM_REQ - int'(rr_ptr_q)) % NUM_REQ);
      end
   end

   // rank = number of non-empty heads ahead in scan order; rank < NUM_CDB wins
   always_comb begin
      logic [RK_W-1:0] r;
      grant = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         r = '0;
         for (int j = 0; j < NUM_REQ; j++) begin
            if (nonempty[j] && (pos[j] < pos[i])) begin
               r = r + RK_W'(1);
            end
         end
         rank[i]  = r;
         grant[i] = nonempty[i] && (r < RK_W'(NUM_CDB)) && !kill;
      end
   end

   // Slot k carries the grant of rank k; rr_ptr moves past the last grant
   always_comb begin
      logic [RK_W-1:0] best;
      slot     = '0;
      rr_ptr_d = rr_ptr_q;
      best     = '0;
      for (int s = 0; s < NUM_CDB; s++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i] && (rank[i] == RK_W'(s))) begin
               slot[s] = head[i];
            end
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i] && (rank[i] >= best)) begin
            best     = rank[i];
            rr_ptr_d = RR_W'((i + 1) % NUM_REQ);
         end
      end
   end

   // FIFO bookkeeping; a full FIFO accepts a push only when popped this cycle
   always_comb begin
      overflow_d = overflow_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         push[i]     = bus.req_cdb[i].valid && !kill && (!full[i] || grant[i]);
         rd_ptr_d[i] = rd_ptr_q[i];
         wr_ptr_d[i] = wr_ptr_q[i];
         cnt_d[i]    = cnt_q[i];
         if (bus.req_cdb[i].valid && !kill && full[i] && !grant[i]) begin
            overflow_d = 1'b1;
         end
         if (flush) begin
            rd_ptr_d[i] = '0;
            wr_ptr_d[i] = '0;
            cnt_d[i]    = '0;
         end else begin
            if (grant[i]) begin
               rd_ptr_d[i] = ptr_inc(rd_ptr_q[i]);
            end
            if (push[i]) begin
               wr_ptr_d[i] = ptr_inc(wr_ptr_q[i]);
            end
            cnt_d[i] = cnt_q[i] + CNT_W'(push[i]) - CNT_W'(grant[i]);
         end
         ready_d[i] = (cnt_d[i] < CNT_W'(BUF_DEPTH));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q   <= '0;
         overflow_q <= 1'b0;
         ready_q    <= '1;
         for (int i = 0; i < NUM_REQ; i++) begin
            rd_ptr_q[i] <= '0;
            wr_ptr_q[i] <= '0;
            cnt_q[i]    <= '0;
         end
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         overflow_q <= overflow_d;
         ready_q    <= ready_d;
         for (int i = 0; i < NUM_REQ; i++) begin
            rd_ptr_q[i] <= rd_ptr_d[i];
            wr_ptr_q[i] <= wr_ptr_d[i];
            cnt_q[i]    <= cnt_d[i];
         end
      end
   end

   // Payload storage needs no reset: occupancy counters gate every read
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REQ; i++) begin
         if (push[i]) begin
            mem_q[i][wr_ptr_q[i]] <= bus.req_cdb[i];
         end
      end
   end

   assign bus.cdb_out   = slot;
   assign bus.cdb_grant = grant;
   assign bus.req_ready = ready_q;
   assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: queue-based reference model predicts every
// cycle's outputs; a negedge monitor pops and compares them.
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   localparam int unsigned NUM_REQ   = 5;
   localparam int unsigned NUM_CDB   = 2;
   localparam int unsigned BUF_DEPTH = 2;

   typedef struct packed {
      logic [NUM_REQ-1:0] grant;
      cdb_t [NUM_CDB-1:0] slot;
      logic [NUM_REQ-1:0] ready;
      logic               ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   cdb_arbiter_if #(.NUM_REQ(NUM_REQ), .NUM_CDB(NUM_CDB)) bus ();

   cdb_arbiter #(
      .NUM_REQ(NUM_REQ),
      .NUM_CDB(NUM_CDB),
      .BUF_DEPTH(BUF_DEPTH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   exp_t               exp_q [$];
   cdb_t               mq [NUM_REQ][$];
   cdb_t               pend [NUM_REQ];
   int                 m_rr;
   logic [NUM_REQ-1:0] m_ready;
   logic               m_ovf;
   int                 n_checks;
   int                 n_pass;
   exp_t               mon_e;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
   endtask

   function automatic cdb_t rand_entry();
      cdb_t e;
      e.valid     = 1'b1;
      e.rob_idx   = ROB_IDX_W'($urandom);
      e.pd_s      = PREG_W'($urandom);
      e.rd_s      = AREG_W'($urandom);
      e.rd_v      = $urandom;
      e.inst      = $urandom;
      e.pc_select = 1'($urandom);
      e.pc_branch = $urandom;
      return e;
   endfunction

   task automatic fill_pend();
      for (int i = 0; i < NUM_REQ; i++) pend[i] = rand_entry();
   endtask

   // Drive one cycle, record the predicted outputs, advance the model.
   task automatic step(input logic r, input logic f, input logic [NUM_REQ-1:0] v);
      exp_t               e;
      logic [NUM_REQ-1:0] g;
      logic [NUM_REQ-1:0] wf;
      int                 n;
      int                 last;
      rst = r;
      bus.global_branch_signal = f;
      for (int i = 0; i < NUM_REQ; i++) bus.req_cdb[i] = v[i] ? pend[i] : '0;
      if (r) begin
         for (int i = 0; i < NUM_REQ; i++) mq[i].delete();
         m_rr    = 0;
         m_ovf   = 1'b0;
         m_ready = '1;
      end else begin
         e    = '0;
         g    = '0;
         n    = 0;
         last = -1;
         if (!f) begin
            for (int k = 0; k < NUM_REQ; k++) begin
               int j;
               j = (m_rr + k) % NUM_REQ;
               if (mq[j].size() > 0 && n < NUM_CDB) begin
                  g[j]      = 1'b1;
                  e.slot[n] = mq[j][0];
                  n++;
                  last = j;
               end
            end
         end
         e.grant = g;
         e.ready = m_ready;
         e.ovf   = m_ovf;
         exp_q.push_back(e);
         if (f) begin
            for (int i = 0; i < NUM_REQ; i++) mq[i].delete();
         end else begin
            for (int i = 0; i < NUM_REQ; i++) wf[i] = (mq[i].size() == BUF_DEPTH);
            for (int i = 0; i < NUM_REQ; i++) if (g[i]) void'(mq[i].pop_front());
            for (int i = 0; i < NUM_REQ; i++) begin
               if (v[i]) begin
                  if (wf[i] && !g[i]) m_ovf = 1'b1;
                  else mq[i].push_back(pend[i]);
               end
            end
            if (last >= 0) m_rr = (last + 1) % NUM_REQ;
         end
         for (int i = 0; i < NUM_REQ; i++) m_ready[i] = (mq[i].size() < BUF_DEPTH);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int c = 0; c < n; c++) step(1'b0, 1'b0, '0);
   endtask

   // Monitor: compare whatever the DUT presents against the oldest prediction
   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("cdb_grant", 128'(bus.cdb_grant), 128'(mon_e.grant));
            for (int s = 0; s < NUM_CDB; s++)
               check($sformatf("cdb_out[%0d]", s), 128'(bus.cdb_out[s]), 128'(mon_e.slot[s]));
            check("req_ready", 128'(bus.req_ready), 128'(mon_e.ready));
            check("overflow", 128'(bus.overflow), 128'(mon_e.ovf));
         end
      end
   end

   initial begin
      logic [NUM_REQ-1:0] v;
      logic               f;
      n_checks = 0;
      n_pass   = 0;
      rst      = 1'b1;
      bus.global_branch_signal = 1'b0;
      bus.req_cdb = '0;
      for (int i = 0; i < NUM_REQ; i++) pend[i] = '0;
      m_rr = 0; m_ovf = 1'b0; m_ready = '1;
      @(posedge clk);
      #1;
      step(1'b1, 1'b0, '0);
      step(1'b1, 1'b0, '0);
      idle(2);

      // single add result
      fill_pend();
      pend[0].rd_v    = 32'h1234;
      pend[0].rob_idx = 5'd3;
      step(1'b0, 1'b0, 5'b00001);
      idle(3);

      // round-robin rotation from rr_ptr = 0
      step(1'b1, 1'b0, '0);
      fill_pend();
      step(1'b0, 1'b0, 5'b11111);
      idle(4);

      // flush with three entries buffered plus a same-cycle mul push
      fill_pend();
      step(1'b0, 1'b0, 5'b11111);
      idle(1);
      fill_pend();
      step(1'b0, 1'b1, 5'b00010);
      idle(3);

      // push and pop on a full FIFO in the same cycle
      step(1'b1, 1'b0, '0);
      for (int c = 0; c < 4; c++) begin
         fill_pend();
         step(1'b0, 1'b0, 5'b00111);
      end
      idle(4);

      // saturate all requesters ignoring ready: drops and sticky overflow
      for (int c = 0; c < 4; c++) begin
         fill_pend();
         step(1'b0, 1'b0, 5'b11111);
      end
      idle(6);
      step(1'b0, 1'b1, '0);
      idle(2);

      // reset mid-stream with entries buffered and a push present
      fill_pend();
      step(1'b0, 1'b0, 5'b11111);
      fill_pend();
      step(1'b1, 1'b0, 5'b11111);
      fill_pend();
      step(1'b0, 1'b0, 5'b11111);
      idle(4);

      // random stress with a scheduler that honours req_ready
      for (int c = 0; c < 3000; c++) begin
         fill_pend();
         f = ($urandom_range(0, 99) < 3);
         for (int i = 0; i < NUM_REQ; i++) v[i] = m_ready[i] & 1'($urandom_range(0, 1));
         step(1'b0, f, v);
      end
      idle(8);

      @(negedge clk);
      #1;
      check("pending_expectations", 128'(exp_q.size()), 128'(0));
      check("overflow_after_stress", 128'(bus.overflow), 128'(0));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Shares `NUM_CDB` common-data-bus broadcast ports among `NUM_REQ` functional-unit result streams (add, mul, div, br, mem-load), which the execute stage otherwise drives as independent `cdb_t` outputs. Each requester gets a small result FIFO. Up to `NUM_CDB` FIFO heads are granted per cycle in round-robin order, and the result is driven onto the shared CDB ports. The block sits between the execute stage and the ROB/reservation-station/regfile wakeup logic. It is flushed by `global_branch_signal`.

## Interface
- `NUM_REQ`, 5, number of result requesters; index 0 add, 1 mul, 2 div, 3 br, 4 mem.
- `NUM_CDB`, 2, number of shared CDB broadcast ports; must satisfy 1 ≤ `NUM_CDB` ≤ `NUM_REQ`.
- `BUF_DEPTH`, 2, result FIFO entries per requester; must be ≥ 1.
- `clk`  in  1  clock; the block uses a single clock.
- `rst`  in  1  reset; synchronous and active-high.
- `global_branch_signal`  in  1  flush request.
- `req_cdb[NUM_REQ]`  in  `cdb_t`  FU results; `.valid` marks a push.
- `req_ready[NUM_REQ]`  out  1  registered; asserted when the FIFO holds fewer than `BUF_DEPTH` entries. Schedulers gate `start` on it.
- `cdb_out[NUM_CDB]`  out  `cdb_t`  shared broadcasts; `.valid` marks a live slot.
- `cdb_grant`  out  `NUM_REQ`  one-hot-per-grant mask of the FIFO heads popped this cycle.
- `overflow`  out  1  sticky error flag: a push arrived to a full FIFO with no simultaneous pop.

## Operation
- **Push:** at posedge, if `req_cdb[i].valid` and no flush, the entry is written to the tail of FIFO i.
- **Push when full:** if FIFO i is full and is not popped this cycle, the push is dropped and `overflow` is set to 1.
- **Push/pop on a full FIFO:** when FIFO i is full and popped in the same cycle, the push is accepted.
- **Arbitration:** combinational over the non-empty FIFO heads. Scanning starts at `rr_ptr` and proceeds in increasing index order modulo `NUM_REQ`. The first `NUM_CDB` non-empty heads are granted.
  - The k-th grant in scan order drives `cdb_out[k]`.
  - Unused slots drive `'0`.
- **Pop:** each granted FIFO pops at posedge.
- **`rr_ptr` update:** if at least one grant occurred, `rr_ptr` becomes (last granted index + 1) mod `NUM_REQ`. Otherwise it holds.
- **Flush:** when `global_branch_signal` = 1:
  - `cdb_out` and `cdb_grant` are forced to `'0` combinationally in the same cycle.
  - All FIFOs are emptied at the next edge.
  - Same-cycle pushes are discarded.
  - `rr_ptr` holds.
  - `overflow` is not cleared.
- **Field passthrough:** entries pass through unmodified, including `rob_idx`, `pd_s`, `rd_s`, `rd_v`, `inst`, `pc_select` and `pc_branch`.
- **Ordering:** within one requester, order is FIFO. No ordering is guaranteed across requesters.
- **Reset:** all FIFOs empty, `rr_ptr` = 0, `overflow` = 0, `req_ready` = all 1, `cdb_out` = `'0`, `cdb_grant` = 0.
- **Reset dominance:** `rst` has priority over flush and push. Reset mid-stream discards all buffered results.

## Timing
- **Latency:** minimum 1 cycle. A push in cycle N appears on `cdb_out` in cycle N+1 if granted. There is no same-cycle bypass.
- **Worst case:** while all requesters are saturated, each non-empty head is granted within ceil(`NUM_REQ`/`NUM_CDB`) cycles.
- **`req_ready`:** registered from the post-edge occupancy. It therefore reflects pushes and pops of the previous cycle only.
  - Fixed-latency units (mul, div) must reserve their slot at issue.
  - Overflow indicates a scheduler bug, not a legal backpressure case.
- **Occupancy counters:** `$clog2(BUF_DEPTH+1)` bits. FIFO pointers wrap modulo `BUF_DEPTH`.

## Test plan
- **Single result:** add pushes `rd_v`=0x1234, `rob_idx`=3 in cycle 0 → cycle 1 shows `cdb_out[0].valid`=1 with the same fields, `cdb_out[1]`=`'0`, `cdb_grant`=5'b00001; cycle 2 shows all outputs zero.
- **Round-robin rotation:** `rr_ptr`=0, all 5 requesters push in cycle 0.
  - Cycle 1: `cdb_out[0]`/`[1]` = req0/req1, `rr_ptr`→2.
  - Cycle 2: req2/req3, `rr_ptr`→4.
  - Cycle 3: req4 only, `rr_ptr`→0.
- **Flush mid-stream:** 3 entries are buffered, and `global_branch_signal` = 1 in cycle 5 together with a new mul push → cycle 5 outputs are zero; from cycle 6 nothing is broadcast and `req_ready` = all 1 in cycle 7.
- **Full FIFO:** with `BUF_DEPTH`=2, div pushes 3 times while starved by other requesters → `overflow`=1 and the third entry is never broadcast. Separately, a push to a full FIFO in the same cycle as its pop → accepted, `overflow` stays 0.
- **Reset mid-operation:** `rst` asserted with 4 entries buffered and a push present → next cycle all outputs are at reset values, `overflow`=0, `rr_ptr`=0.
- **Random stress:** scheduler model honours `req_ready` → every pushed entry is broadcast exactly once, per-requester order is preserved, and `overflow` never sets.
